// File: rtl/bus_decoder_n_if.sv
// ---------------------------------------------------------------------------
// bus_decoder_n_if
//
// Purpose:
//   Bundles the master-side and slave-side signals of the req/addr_ok/data_ok
//   memory bus that pass through bus_decoder_n. The decoder takes the "slave"
//   modport, because it answers the core's requests. The environment (the
//   core plus the slave targets, or a testbench) takes the "master" modport.
//
// Signal summary:
//   m_req, m_write     core request / write flag
//   m_wstrb            core byte strobes (XLEN/8)
//   m_addr, m_wdata    core address / write data (XLEN)
//   m_addr_ok          request accepted this cycle
//   m_data_ok          response valid
//   m_rdata            response data (XLEN)
//   m_err              response is a decode error (qualified by m_data_ok)
//   s_req              per-slave request (NSLV)
//   s_write, s_wstrb,
//   s_addr, s_wdata    broadcast copies of the master fields
//   s_addr_ok          per-slave accept (NSLV)
//   s_data_ok          per-slave response valid (NSLV)
//   s_rdata            per-slave read data, slave i in slice i (NSLV*XLEN)
// ---------------------------------------------------------------------------
interface bus_decoder_n_if #(
  parameter int XLEN = 32,
  parameter int NSLV = 2
);

  logic                 m_req;
  logic                 m_write;
  logic [XLEN/8-1:0]    m_wstrb;
  logic [XLEN-1:0]      m_addr;
  logic [XLEN-1:0]      m_wdata;
  logic                 m_addr_ok;
  logic                 m_data_ok;
  logic [XLEN-1:0]      m_rdata;
  logic                 m_err;

  logic [NSLV-1:0]      s_req;
  logic                 s_write;
  logic [XLEN/8-1:0]    s_wstrb;
  logic [XLEN-1:0]      s_addr;
  logic [XLEN-1:0]      s_wdata;
  logic [NSLV-1:0]      s_addr_ok;
  logic [NSLV-1:0]      s_data_ok;
  logic [NSLV*XLEN-1:0] s_rdata;

  // Decoder view: responds to the core, drives the slave targets.
  modport slave (
    input  m_req, m_write, m_wstrb, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata, m_err,
    output s_req, s_write, s_wstrb, s_addr, s_wdata,
    input  s_addr_ok, s_data_ok, s_rdata
  );

  // Environment view: the core side issues requests, the targets answer.
  modport master (
    output m_req, m_write, m_wstrb, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata, m_err,
    input  s_req, s_write, s_wstrb, s_addr, s_wdata,
    output s_addr_ok, s_data_ok, s_rdata
  );

endinterface

// File: rtl/bus_decoder_n.sv
// ---------------------------------------------------------------------------
// bus_decoder_n
//
// Purpose:
//   1-master-to-N-slave decoder for the core's req/addr_ok/data_ok bus.
//   Each request is routed by address region to one slave target. A request
//   that matches no region is accepted locally and answered with an error
//   response. An order FIFO of target tags remembers who owes each response,
//   so data_ok/rdata are always taken from the slave at the head of the FIFO.
//   Requests are only issued to the slave that already owns the outstanding
//   requests (or to anyone when nothing is outstanding), so responses can
//   never come back out of order.
//
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   bus   slave modport of bus_decoder_n_if (see that file for the signals)
//
// Parameters:
//   XLEN       data/address width
//   NSLV       number of slaves (1..8)
//   DEPTH      max outstanding requests (power of 2, >= 2)
//   SLV_BASE   packed region bases, slave i uses slice i
//   SLV_MASK   packed region masks, match when (addr & mask) == base
//   ERR_RDATA  rdata returned on a decode error
// ---------------------------------------------------------------------------
module bus_decoder_n #(
  parameter int                   XLEN      = 32,
  parameter int                   NSLV      = 2,
  parameter int                   DEPTH     = 4,
  parameter logic [NSLV*XLEN-1:0] SLV_BASE  = {32'h2000_0000, 32'h0000_0000},
  parameter logic [NSLV*XLEN-1:0] SLV_MASK  = {32'hF000_0000, 32'hE000_0000},
  parameter logic [XLEN-1:0]      ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic           clk,
  input  logic           rst,
  bus_decoder_n_if.slave bus
);

  // Tag NSLV is reserved for "no region matched"; it needs one more code
  // than there are slaves.
  localparam int TAGW = $clog2(NSLV + 1);
  localparam int PTRW = $clog2(DEPTH);
  localparam int OCCW = PTRW + 1;

  localparam logic [TAGW-1:0] ERR_TAG = TAGW'(NSLV);

  // Order FIFO storage and bookkeeping
  logic [TAGW-1:0] tagFifo_q [DEPTH];
  logic [PTRW-1:0] wrPtr_q, wrPtr_d;
  logic [PTRW-1:0] rdPtr_q, rdPtr_d;
  logic [OCCW-1:0] occCount_q, occCount_d;
  logic [TAGW-1:0] lastTag_q, lastTag_d;

  // Request-side decode
  logic [TAGW-1:0] target;
  logic            fifoFull;
  logic            fifoEmpty;
  logic            issueOk;
  logic            targetAddrOk;
  logic [NSLV-1:0] slaveReq;
  logic            addrOk;
  logic            doPush;

  // Response-side steering
  logic [TAGW-1:0] headTag;
  logic            respValid;
  logic [XLEN-1:0] respData;
  logic            respErr;
  logic            doPop;

  // Address decode. Scanning from the highest index down and overwriting
  // means the lowest matching region is the one left in target when
  // regions overlap. No match leaves the error tag.
  always_comb begin
    target = ERR_TAG;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((bus.m_addr & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN]) begin
        target = TAGW'(i);
      end
    end
  end

  // Full/empty come from the registered occupancy only, so a pop in the
  // same cycle never frees room for a push; this keeps the accept path free
  // of any dependency on s_data_ok.
  assign fifoFull  = (occCount_q == OCCW'(DEPTH));
  assign fifoEmpty = (occCount_q == '0);

  // A new request may go out only to the slave that owns every outstanding
  // entry. Switching targets therefore waits for the FIFO to drain, which is
  // what keeps responses in order without any reordering storage.
  assign issueOk = !fifoFull && (fifoEmpty || (target == lastTag_q));

  // Fan the request out to the decoded slave and pick up its addr_ok. An
  // error-target request is accepted by the decoder itself as soon as it is
  // allowed to issue.
  always_comb begin
    slaveReq     = '0;
    targetAddrOk = 1'b0;
    for (int t = 0; t < NSLV; t++) begin
      if (target == TAGW'(t)) begin
        slaveReq[t]  = bus.m_req & issueOk;
        targetAddrOk = bus.s_addr_ok[t];
      end
    end
    if (target == ERR_TAG) begin
      targetAddrOk = 1'b1;
    end
  end

  assign addrOk = bus.m_req & issueOk & targetAddrOk;
  assign doPush = addrOk;

  assign bus.s_req     = slaveReq;
  assign bus.s_write   = bus.m_write;
  assign bus.s_wstrb   = bus.m_wstrb;
  assign bus.s_addr    = bus.m_addr;
  assign bus.s_wdata   = bus.m_wdata;
  assign bus.m_addr_ok = addrOk;

  assign headTag = tagFifo_q[rdPtr_q];

  // Response steering from the head of the order FIFO. Only the slave named
  // by the head tag is listened to; data_ok from any other slave, or while
  // nothing is outstanding, is simply dropped. An error entry answers by
  // itself in the cycle it reaches the head. All response outputs are held
  // at zero whenever no response is being returned.
  always_comb begin
    respValid = 1'b0;
    respData  = '0;
    respErr   = 1'b0;
    if (!fifoEmpty) begin
      if (headTag == ERR_TAG) begin
        respValid = 1'b1;
        respData  = ERR_RDATA;
        respErr   = 1'b1;
      end else begin
        for (int t = 0; t < NSLV; t++) begin
          if ((headTag == TAGW'(t)) && bus.s_data_ok[t]) begin
            respValid = 1'b1;
            respData  = bus.s_rdata[t*XLEN +: XLEN];
          end
        end
      end
    end
  end

  assign doPop = respValid;

  assign bus.m_data_ok = respValid;
  assign bus.m_rdata   = respData;
  assign bus.m_err     = respErr;

  // Next-state for the FIFO bookkeeping. Pointers wrap naturally because
  // DEPTH is a power of two. A simultaneous push and pop leaves the
  // occupancy unchanged.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    occCount_d = occCount_q;
    lastTag_d  = lastTag_q;
    if (doPush) begin
      wrPtr_d   = wrPtr_q + PTRW'(1);
      lastTag_d = target;
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + PTRW'(1);
    end
    case ({doPush, doPop})
      2'b10:   occCount_d = occCount_q + OCCW'(1);
      2'b01:   occCount_d = occCount_q - OCCW'(1);
      default: occCount_d = occCount_q;
    endcase
  end

  // FIFO bookkeeping registers. Reset empties the FIFO and clears the
  // last-issued tag, so any data_ok still in flight from before the reset
  // lands on an empty FIFO and is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      occCount_q <= '0;
      lastTag_q  <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      occCount_q <= occCount_d;
      lastTag_q  <= lastTag_d;
    end
  end

  // Tag storage needs no reset: an entry is only ever read while the
  // occupancy says it holds a pushed tag.
  always_ff @(posedge clk) begin
    if (!rst && doPush) begin
      tagFifo_q[wrPtr_q] <= target;
    end
  end

endmodule

// File: doc/bus_decoder_n.md
# bus_decoder_n

Parametrised 1-master-to-N-slave decoder for the core's req/addr_ok/data_ok memory bus. It sits between the core's data port and the SoC targets: RAM, GPIO and future peripherals. It routes each request by address region and tracks outstanding requests in an order FIFO, so every data_ok/rdata is returned from the slave that owes it. An address that matches no region gets an error response.

## Interface
- XLEN, 32, data/address width
- NSLV, 2, number of slaves (1..8)
- DEPTH, 4, max outstanding requests (power of 2, ≥2)
- SLV_BASE, {32'h2000_0000, 32'h0000_0000}, NSLV×XLEN packed region base addresses; slave i uses slice i
- SLV_MASK, {32'hF000_0000, 32'hE000_0000}, NSLV×XLEN packed region masks; match when (addr & mask) == base
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on decode error
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- m_req / m_write  in  1  master request / write
- m_wstrb  in  XLEN/8  byte strobes
- m_addr / m_wdata  in  XLEN  address / write data
- m_addr_ok  out  1  request accepted this cycle
- m_data_ok  out  1  response valid
- m_rdata  out  XLEN  response data
- m_err  out  1  response is decode error (qualified by m_data_ok)
- s_req  out  NSLV  per-slave request
- s_write, s_wstrb, s_addr, s_wdata  out  1/XLEN/8/XLEN/XLEN  broadcast copies of master fields
- s_addr_ok / s_data_ok  in  NSLV  per-slave handshakes
- s_rdata  in  NSLV×XLEN  per-slave read data

## Operation
- Decode: combinational; lowest matching index wins; no match → target ERR (tag NSLV).
- Order FIFO: DEPTH entries of target tag ($clog2(NSLV+1) bits); occupancy counter 0..DEPTH; read/write pointers wrap modulo DEPTH.
- Issue rule: s_req[t] = m_req & (t == decoded target) & issue_ok.
- issue_ok = !full & (empty | decoded target == last-issued tag). This forbids interleaving across slaves and keeps responses in order.
- m_addr_ok = issue_ok & (target==ERR ? m_req : s_addr_ok[target]). Push the tag when m_req & m_addr_ok. Writes are tracked the same as reads, since slaves return data_ok for writes too.
- Response: head tag h, FIFO not empty.
  - If h<NSLV: m_data_ok = s_data_ok[h], m_rdata = s_rdata[h], m_err = 0.
  - If h==ERR: m_data_ok = 1, m_rdata = ERR_RDATA, m_err = 1.
  - Pop when m_data_ok.
- When m_data_ok=0, m_rdata=0 and m_err=0.
- s_data_ok from a non-head slave, or while the FIFO is empty: ignored, and no pop.
- Simultaneous push and pop: allowed; occupancy is unchanged.
  - full is evaluated on registered occupancy, so a same-cycle pop does not unblock a push.
- Reset mid-operation: FIFO emptied and last-issued tag cleared. Slave data_ok arriving after reset is dropped per the empty rule.
- Reset values: m_addr_ok=0 (until m_req), m_data_ok=0, m_rdata=0, m_err=0, s_req=0, occupancy=0.

## Timing
- Request path: purely combinational, with zero added cycles (m_addr → s_req, s_addr_ok → m_addr_ok).
- Response path: combinational from s_data_ok/s_rdata to m_data_ok/m_rdata.
- Error response: m_data_ok is asserted the cycle after acceptance at the earliest, once ERR reaches the head. Back-to-back ERR entries return one per cycle.
- Throughput: one accept and one response per cycle sustained to a single slave. Switching slaves costs a drain to empty.

## Test plan
- Read 0x0000_0040 (slave0) and read 0x2000_0004 (slave1), each with a 1-cycle slave latency → s_req[0] then s_req[1]. The slave1 request is held until the slave0 data_ok. Responses are returned in order with the correct rdata and m_err=0.
- 4 back-to-back reads to slave0 with the slave withholding data_ok → occupancy reaches 4 and the 5th request sees m_addr_ok=0. The first data_ok pops, and m_addr_ok rises the following cycle.
- Read 0x4000_0000 (no match) → m_addr_ok=1 and no s_req. The next cycle m_data_ok=1, m_rdata=0xDEAD_BEEF, m_err=1.
- Pulse s_data_ok[1] while the head is slave0 or the FIFO is empty → m_data_ok stays 0 and occupancy is unchanged.
- Full FIFO with simultaneous head data_ok and a new m_req → the new request is not accepted that cycle but is accepted the next. Occupancy sequence: 4→3→4.
- Assert rst with 3 requests outstanding, then return slave data_ok → all outputs are 0 and the late data_ok is ignored. A fresh read then completes normally.
